// File: rtl/sram_bw_clr_pkg.sv
// Shared types and helpers for the byte-writable SRAM with clear engine.
// Holds clear-FSM state encoding, byte-lane width and the byte-merge function.
// Pure declarations: no latency, no flow control.
package sram_pkg;

    localparam int BYTE_W = 8;
    // Widest data word the merge helper handles; callers widen/narrow with casts.
    localparam int MAX_DW = 256;
    localparam int MAX_NB = MAX_DW / BYTE_W;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_e;

    // Replace each byte lane of old_w with new_w where the active-low enable is 0.
    function automatic logic [MAX_DW-1:0] merge_bytes(
        input logic [MAX_DW-1:0] old_w,
        input logic [MAX_DW-1:0] new_w,
        input logic [MAX_NB-1:0] bwen_n
    );
        logic [MAX_DW-1:0] res;
        res = old_w;
        for (int i = 0; i < MAX_NB; i++) begin
            if (!bwen_n[i]) begin
                res[i*BYTE_W +: BYTE_W] = new_w[i*BYTE_W +: BYTE_W];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sram_bw_clr_if.sv
// Access bus of the SRAM: request side driven by the master, status/read side by the slave.
// Signal timing is defined by the SRAM; the interface adds no latency.
// BUSY from the slave tells the master that accesses are being dropped.
interface sram_bw_clr_if #(
    parameter int DW    = 32,
    parameter int DEPTH = 128
);
    localparam int AW = $clog2(DEPTH);
    localparam int NB = DW / 8;

    logic          CEN;
    logic          WEN;
    logic [AW-1:0] A;
    logic [DW-1:0] D;
    logic [NB-1:0] BWEN;
    logic          CLR;
    logic          BUSY;
    logic [DW-1:0] Q;
    logic          Q_VALID;

    modport master (
        output CEN, WEN, A, D, BWEN, CLR,
        input  BUSY, Q, Q_VALID
    );

    modport slave (
        input  CEN, WEN, A, D, BWEN, CLR,
        output BUSY, Q, Q_VALID
    );

endinterface

// File: rtl/sram_clr_seq.sv
// Clear sequencer: walks every address once, asking the top to write zero there.
// Starts the edge after clr_req_i in idle; busy_o stays high for exactly DEPTH cycles.
// Requests while busy are ignored; the walk cannot be restarted, only aborted by reset.
module sram_clr_seq
    import sram_pkg::*;
#(
    parameter int DEPTH = 128,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_req_i,
    output logic          busy_o,
    output logic          clr_we_o,
    output logic [AW-1:0] clr_addr_o
);

    clr_state_e    state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;

    // State and address counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: idle waits for a request, clear counts up to the last word.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (clr_req_i) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            ST_CLEAR: begin
                if (cnt_q == AW'(DEPTH - 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy_o     = (state_q == ST_CLEAR);
    assign clr_we_o   = (state_q == ST_CLEAR);
    assign clr_addr_o = cnt_q;

endmodule

// File: rtl/sram_bw_clr.sv
// Single-port SRAM with active-low byte write mask, registered read and self-timed clear.
// Read latency 1 (2 when SRAM_OREG_EN is defined); writes land at the request edge.
// No backpressure: accesses issued while BUSY (or together with CLR) are silently dropped.
module sram_bw_clr
    import sram_pkg::*;
#(
    parameter  int DW    = 32,
    parameter  int DEPTH = 128,
    localparam int AW    = $clog2(DEPTH),
    localparam int NB    = DW / 8
) (
    input  logic              CLK,
    input  logic              RESET_N,
    sram_bw_clr_if.slave      bus
);

    logic [DW-1:0] mem_q [DEPTH];

    logic          busy;
    logic          clr_we;
    logic [AW-1:0] clr_addr;

    logic          acc_ok;
    logic          in_range;
    logic          rd_en;
    logic          usr_we;
    logic [DW-1:0] rd_word;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdat;

    logic [DW-1:0] q_q;
    logic          qv_q;

    sram_clr_seq #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_clr_seq (
        .clk        (CLK),
        .rst_n      (RESET_N),
        .clr_req_i  (bus.CLR),
        .busy_o     (busy),
        .clr_we_o   (clr_we),
        .clr_addr_o (clr_addr)
    );

    // Access decode and write-port mux: the clear engine owns the port while busy.
    always_comb begin
        acc_ok   = !busy && !bus.CLR && !bus.CEN;
        in_range = ({1'b0, bus.A} < (AW + 1)'(DEPTH));
        rd_en    = acc_ok && bus.WEN;
        usr_we   = acc_ok && !bus.WEN && in_range;
        rd_word  = in_range ? mem_q[bus.A] : '0;
        mem_we   = clr_we || usr_we;
        mem_addr = clr_we ? clr_addr : bus.A;
        mem_wdat = clr_we ? '0
                 : DW'(merge_bytes(MAX_DW'(rd_word), MAX_DW'(bus.D), MAX_NB'(bus.BWEN)));
    end

    // Storage array; intentionally not reset so a reset mid-clear keeps untouched words.
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem_q[mem_addr] <= mem_wdat;
        end
    end

    // Read register: Q holds between reads, strobe marks the cycle a read completes.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            q_q  <= '0;
            qv_q <= 1'b0;
        end else begin
            qv_q <= rd_en;
            if (rd_en) begin
                q_q <= rd_word;
            end
        end
    end

`ifdef SRAM_OREG_EN
    logic [DW-1:0] q2_q;
    logic          qv2_q;

    // Extra output stage for timing; the held value simply shifts through it.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            q2_q  <= '0;
            qv2_q <= 1'b0;
        end else begin
            q2_q  <= q_q;
            qv2_q <= qv_q;
        end
    end

    assign bus.Q       = q2_q;
    assign bus.Q_VALID = qv2_q;
`else
    assign bus.Q       = q_q;
    assign bus.Q_VALID = qv_q;
`endif

    assign bus.BUSY = busy;

endmodule

// File: tb/tb_sram_bw_clr.sv
// Bench for sram_bw_clr: a DEPTH=128 and a DEPTH=100 instance share one stimulus stream.
// Each instance has its own behavioural model (plain array + remaining-clear-cycles count).
// Outputs are compared every cycle on the falling edge; directed checks use constants.
module tb_sram_bw_clr;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Shared stimulus
    logic        cen_s  = 1'b1;
    logic        wen_s  = 1'b1;
    logic [6:0]  a_s    = '0;
    logic [31:0] d_s    = '0;
    logic [3:0]  bwen_s = 4'hF;
    logic        clr_s  = 1'b0;

    sram_bw_clr_if #(.DW(32), .DEPTH(128)) if128 ();
    sram_bw_clr_if #(.DW(32), .DEPTH(100)) if100 ();

    assign if128.CEN = cen_s;  assign if100.CEN = cen_s;
    assign if128.WEN = wen_s;  assign if100.WEN = wen_s;
    assign if128.A   = a_s;    assign if100.A   = a_s;
    assign if128.D   = d_s;    assign if100.D   = d_s;
    assign if128.BWEN = bwen_s; assign if100.BWEN = bwen_s;
    assign if128.CLR = clr_s;  assign if100.CLR = clr_s;

    sram_bw_clr #(.DW(32), .DEPTH(128)) dut128 (.CLK(clk), .RESET_N(rst_n), .bus(if128.slave));
    sram_bw_clr #(.DW(32), .DEPTH(100)) dut100 (.CLK(clk), .RESET_N(rst_n), .bus(if100.slave));

    // Reference model state, index 0 = DEPTH 128, index 1 = DEPTH 100
    int          depth_m [2] = '{128, 100};
    logic [31:0] mem_m   [2][128];
    int          rem_m   [2];
    logic [31:0] q1_m    [2];
    logic        qv1_m   [2];
    logic [31:0] q2_m    [2];
    logic        qv2_m   [2];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic mdl_reset();
        for (int k = 0; k < 2; k++) begin
            rem_m[k] = 0;
            q1_m[k] = '0; qv1_m[k] = 1'b0;
            q2_m[k] = '0; qv2_m[k] = 1'b0;
        end
    endtask

    // One clock edge of the specified behaviour for instance k.
    task automatic mdl_step(input int k);
        int dep;
        dep = depth_m[k];
        q2_m[k]  = q1_m[k];
        qv2_m[k] = qv1_m[k];
        qv1_m[k] = 1'b0;
        if (rem_m[k] > 0) begin
            mem_m[k][dep - rem_m[k]] = '0;
            rem_m[k]--;
        end else if (clr_s) begin
            rem_m[k] = dep;
        end else if (!cen_s) begin
            if (wen_s) begin
                qv1_m[k] = 1'b1;
                q1_m[k]  = (int'(a_s) < dep) ? mem_m[k][a_s] : 32'h0;
            end else if (int'(a_s) < dep) begin
                for (int i = 0; i < 4; i++)
                    if (!bwen_s[i]) mem_m[k][a_s][8*i +: 8] = d_s[8*i +: 8];
            end
        end
    endtask

    function automatic logic [31:0] exp_q(input int k);
`ifdef SRAM_OREG_EN
        return q2_m[k];
`else
        return q1_m[k];
`endif
    endfunction

    function automatic logic exp_qv(input int k);
`ifdef SRAM_OREG_EN
        return qv2_m[k];
`else
        return qv1_m[k];
`endif
    endfunction

    task automatic cmp_all();
        chk("busy128", 32'(if128.BUSY),    32'(rem_m[0] > 0));
        chk("qv128",   32'(if128.Q_VALID), 32'(exp_qv(0)));
        chk("q128",    if128.Q,            exp_q(0));
        chk("busy100", 32'(if100.BUSY),    32'(rem_m[1] > 0));
        chk("qv100",   32'(if100.Q_VALID), 32'(exp_qv(1)));
        chk("q100",    if100.Q,            exp_q(1));
    endtask

    task automatic tick();
        @(posedge clk);
        mdl_step(0);
        mdl_step(1);
        @(negedge clk);
        cmp_all();
    endtask

    task automatic drive(input logic cen, input logic wen, input logic [6:0] a,
                         input logic [31:0] d, input logic [3:0] bwen, input logic clr);
        cen_s = cen; wen_s = wen; a_s = a; d_s = d; bwen_s = bwen; clr_s = clr;
    endtask

    task automatic idle();
        drive(1'b1, 1'b1, 7'd0, 32'h0, 4'hF, 1'b0);
    endtask

    // Directed read with a constant expectation on one instance.
    task automatic read_chk(input string tag, input int k, input logic [6:0] a,
                            input logic [31:0] exp);
        drive(1'b0, 1'b1, a, 32'h0, 4'hF, 1'b0);
        tick();
        idle();
`ifdef SRAM_OREG_EN
        tick();
`endif
        chk({tag, "_q"},  (k == 0) ? if128.Q : if100.Q, exp);
        chk({tag, "_qv"}, 32'((k == 0) ? if128.Q_VALID : if100.Q_VALID), 32'd1);
        tick();
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        idle();
        while ((if128.BUSY || if100.BUSY) && n < 300) begin
            tick();
            n++;
        end
        chk("wait_idle", 32'(if128.BUSY || if100.BUSY), 32'd0);
    endtask

    initial begin
        int cnt128, cnt100;
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 128; i++) mem_m[k][i] = '0;
        mdl_reset();
        idle();
        #2;
        cmp_all();
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Full-word write then read back
        drive(1'b0, 1'b0, 7'd5, 32'hDEADBEEF, 4'h0, 1'b0);
        tick();
        read_chk("t1", 0, 7'd5, 32'hDEADBEEF);

        // Byte-masked write merges lanes 0 and 2
        drive(1'b0, 1'b0, 7'd5, 32'h11223344, 4'b1010, 1'b0);
        tick();
        read_chk("t2", 0, 7'd5, 32'hDE22BE44);

        // Out-of-range address on the DEPTH=100 instance
        drive(1'b0, 1'b0, 7'd100, 32'h12345678, 4'h0, 1'b0);
        tick();
        read_chk("t5_oor", 1, 7'd100, 32'h0);
        read_chk("t5_inr", 0, 7'd100, 32'h12345678);

        // CLR together with a write, reads while busy, CLR re-pulse mid-clear
        drive(1'b0, 1'b0, 7'd3, 32'hFFFFFFFF, 4'h0, 1'b1);
        tick();
        cnt128 = 0;
        cnt100 = 0;
        while (if128.BUSY && cnt128 < 300) begin
            drive(1'b0, 1'b1, 7'(cnt128), 32'h0, 4'hF, cnt128 == 50);
            if (if100.BUSY) cnt100++;
            tick();
            if (cnt128 == 10) chk("busy_rd_qv", 32'(if128.Q_VALID), 32'd0);
            cnt128++;
        end
        chk("busy_len128", 32'(cnt128), 32'd128);
        chk("busy_len100", 32'(cnt100), 32'd100);
        idle();
        tick();
        read_chk("t3_a0",   0, 7'd0,   32'h0);
        read_chk("t3_a5",   0, 7'd5,   32'h0);
        read_chk("t3_a127", 0, 7'd127, 32'h0);
        read_chk("t4_a3",   0, 7'd3,   32'h0);

        // Randomised traffic with occasional clears
        for (int c = 0; c < 1500; c++) begin
            drive($urandom_range(0, 2) != 0 ? 1'b0 : 1'b1, 1'($urandom_range(0, 1)),
                  7'($urandom_range(0, 127)), $urandom, 4'($urandom),
                  $urandom_range(0, 199) == 0);
            tick();
        end
        wait_idle();

        // Fill, start clear, reset after 10 cleared words
        for (int a = 0; a < 128; a++) begin
            drive(1'b0, 1'b0, 7'(a), 32'hA5A5A5A5, 4'h0, 1'b0);
            tick();
        end
        read_chk("t6_pre", 0, 7'd20, 32'hA5A5A5A5);
        drive(1'b1, 1'b1, 7'd0, 32'h0, 4'hF, 1'b1);
        tick();
        idle();
        for (int i = 0; i < 10; i++) tick();
        rst_n = 1'b0;
        mdl_reset();
        #1;
        chk("rst_busy", 32'(if128.BUSY), 32'd0);
        chk("rst_q",    if128.Q,         32'h0);
        chk("rst_qv",   32'(if128.Q_VALID), 32'd0);
        cmp_all();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        read_chk("t6_a0",   0, 7'd0,   32'h0);
        read_chk("t6_a9",   0, 7'd9,   32'h0);
        read_chk("t6_a10",  0, 7'd10,  32'hA5A5A5A5);
        read_chk("t6_a127", 0, 7'd127, 32'hA5A5A5A5);
        for (int a = 0; a < 128; a++) begin
            drive(1'b0, 1'b1, 7'(a), 32'h0, 4'hF, 1'b0);
            tick();
        end
        idle();
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
